// File: rtl/wb_imem_arbiter.sv
// Wishbone slave that shares a byte-wide instruction memory between the host bus and a CPU,
// with a RUN control bit and a saturating count of host IMEM writes.
module wb_imem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  cpu_pc_i,
    output logic        cpu_rst_o,
    output logic        cpu_stall_o,
    output logic [7:0]  mem_addr_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StMem, StRdwait, StAck} state_e;

    state_e      state_q, state_d;
    logic        run_q, run_d;
    logic [15:0] wrcnt_q, wrcnt_d;
    logic [31:0] dat_q, dat_d;

    logic [11:0] offset;
    logic        hit, req, wr_en;
    logic        sel_imem, sel_ctrl, sel_status;
    logic        unused_bits;

    assign offset      = wbs_adr_i[11:0];
    assign hit         = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign req         = wbs_cyc_i & wbs_stb_i & hit;
    assign wr_en       = wbs_we_i & wbs_sel_i[0];
    assign sel_imem    = offset[11:10] == 2'b01;
    assign sel_ctrl    = offset == 12'h000;
    assign sel_status  = offset == 12'h004;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            run_q   <= 1'b0;
            wrcnt_q <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            wrcnt_q <= wrcnt_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        wrcnt_d = wrcnt_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // Register reads snapshot their value here; writes and holes return 0.
                    dat_d = '0;
                    if (sel_imem) begin
                        state_d = StMem;
                    end else begin
                        state_d = StAck;
                        if (sel_ctrl && wr_en) begin
                            run_d   = wbs_dat_i[0];
                            wrcnt_d = '0;
                        end else if (sel_ctrl && !wbs_we_i) begin
                            dat_d = {31'b0, run_q};
                        end else if (sel_status && !wbs_we_i) begin
                            dat_d = {15'b0, run_q, wrcnt_q};
                        end
                    end
                end
            end
            StMem: begin
                if (!wbs_cyc_i) begin
                    state_d = StIdle;
                end else if (wbs_we_i) begin
                    state_d = StAck;
                    if (wbs_sel_i[0] && wrcnt_q != 16'hFFFF) begin
                        wrcnt_d = wrcnt_q + 16'd1;
                    end
                end else begin
                    state_d = StRdwait;
                end
            end
            StRdwait: begin
                if (!wbs_cyc_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StAck;
                    dat_d   = {24'b0, mem_rdata_i};
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The host only owns the memory port during MEM; the CPU fetch address is passed through
    // otherwise. A dropped cycle suppresses the write strobe so an abandoned access is harmless.
    always_comb begin
        mem_addr_o  = cpu_pc_i;
        mem_we_o    = 1'b0;
        mem_wdata_o = wbs_dat_i[7:0];
        if (state_q == StMem) begin
            mem_addr_o = offset[9:2];
            mem_we_o   = wbs_cyc_i & wr_en;
        end
    end

    assign wbs_ack_o   = state_q == StAck;
    assign wbs_dat_o   = (state_q == StAck) ? dat_q : 32'h0;
    assign cpu_stall_o = run_q & ((state_q == StMem) | (state_q == StRdwait));
    assign cpu_rst_o   = ~run_q;

endmodule

// File: tb/tb_wb_imem_arbiter.sv
// Randomized self-checking bench for wb_imem_arbiter against a transaction-level model of the
// register map, instruction memory contents, RUN bit and write counter.
module tb_wb_imem_arbiter;

    localparam logic [31:0] Base = 32'h3000_0000;
    localparam logic [31:0] Mask = 32'hFFFF_F000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  cpu_pc_i;
    logic        cpu_rst_o, cpu_stall_o;
    logic [7:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_we_o;

    wb_imem_arbiter dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .cpu_pc_i    (cpu_pc_i),
        .cpu_rst_o   (cpu_rst_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Instruction memory device with synchronous read.
    logic [7:0] mem [256];
    logic       mem_init;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 97 + 13);
        return (i == 4) ? 8'hC3 : v;
    endfunction

    always @(posedge wb_clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end
        mem_rdata_i <= mem[mem_addr_o];
    end

    // Write-strobe monitor, sampled mid-cycle.
    int         we_total = 0;
    logic [7:0] we_addr, we_data;
    always @(negedge wb_clk_i) begin
        if (mem_we_o) begin
            we_total <= we_total + 1;
            we_addr  <= mem_addr_o;
            we_data  <= mem_wdata_o;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [7:0]  shadow [256];
    logic        m_run;
    int unsigned m_wrcnt;

    task automatic model_reset();
        m_run   = 1'b0;
        m_wrcnt = 0;
    endtask

    // Predicts the outcome of one transaction from the register map and updates the model.
    task automatic predict(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, output logic ack, output int lat,
                           output logic [31:0] rdat, output int nwe, output int stall);
        logic [11:0] off;
        int          idx;
        off   = adr[11:0];
        idx   = int'(off[9:2]);
        ack   = 1'b0;
        lat   = 0;
        rdat  = 32'h0;
        nwe   = 0;
        stall = 0;
        if ((adr & Mask) != Base) return;
        ack = 1'b1;
        if (off >= 12'h400 && off <= 12'h7FF) begin
            lat   = we ? 2 : 3;
            stall = m_run ? lat - 1 : 0;
            if (!we) begin
                rdat = {24'h0, shadow[idx]};
            end else if (sel[0]) begin
                nwe         = 1;
                shadow[idx] = dat[7:0];
                m_wrcnt     = (m_wrcnt >= 65535) ? 65535 : m_wrcnt + 1;
            end
        end else begin
            lat = 1;
            if (off == 12'h000) begin
                if (!we) rdat = {31'h0, m_run};
                else if (sel[0]) begin
                    m_run   = dat[0];
                    m_wrcnt = 0;
                end
            end else if (off == 12'h004 && !we) begin
                rdat = {15'h0, m_run, 16'(m_wrcnt)};
            end
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
        logic        e_ack, got, rst_at1;
        int          e_lat, e_we, e_stall, lat, stall, we0;
        logic [31:0] e_dat, rd;
        predict(we, sel, adr, dat, e_ack, e_lat, e_dat, e_we, e_stall);
        we0       = we_total;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        got       = 1'b0;
        lat       = 0;
        stall     = 0;
        rd        = 32'h0;
        rst_at1   = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge wb_clk_i);
            #1;
            if (c == 1) rst_at1 = cpu_rst_o;
            if (cpu_stall_o) stall++;
            if (wbs_ack_o) begin
                got = 1'b1;
                lat = c;
                rd  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check({tag, ".ack"}, {31'h0, got}, {31'h0, e_ack});
        if (e_ack && got) begin
            check({tag, ".lat"}, lat, e_lat);
            check({tag, ".dat"}, rd, e_dat);
        end
        check({tag, ".stall"}, stall, e_stall);
        check({tag, ".wecnt"}, we_total - we0, e_we);
        if (e_we == 1) begin
            check({tag, ".weaddr"}, {24'h0, we_addr}, {24'h0, adr[9:2]});
            check({tag, ".wedata"}, {24'h0, we_data}, {24'h0, dat[7:0]});
        end
        check({tag, ".cpurst"}, {31'h0, rst_at1}, {31'h0, ~m_run});
        check({tag, ".pcpass"}, {24'h0, mem_addr_o}, {24'h0, cpu_pc_i});
    endtask

    initial begin
        logic [31:0] adr;
        int          r, we0;

        wb_rst_i  = 1'b1;
        mem_init  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        cpu_pc_i  = 8'h3C;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        model_reset();
        repeat (3) @(posedge wb_clk_i);
        #1;
        mem_init = 1'b0;
        check("rst.ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst.dat", wbs_dat_o, 32'h0);
        check("rst.we", {31'h0, mem_we_o}, 32'h0);
        check("rst.stall", {31'h0, cpu_stall_o}, 32'h0);
        check("rst.cpurst", {31'h0, cpu_rst_o}, 32'h1);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // Directed scenarios.
        xfer("rd_c3", 1'b0, 4'hF, Base | 32'h410, 32'h0);
        xfer("wr_5a", 1'b1, 4'h1, Base | 32'h410, 32'h5A);
        xfer("status1", 1'b0, 4'hF, Base | 32'h004, 32'h0);
        xfer("rd_5a", 1'b0, 4'hF, Base | 32'h410, 32'h0);
        xfer("ctrl_run", 1'b1, 4'h1, Base, 32'h1);
        xfer("rd_stall", 1'b0, 4'hF, Base | 32'h7FC, 32'h0);
        xfer("ctrl_rd", 1'b0, 4'hF, Base, 32'h0);
        xfer("unmapped", 1'b0, 4'hF, Base | 32'h100, 32'h0);
        xfer("miss", 1'b0, 4'hF, Base + 32'h1000, 32'h0);
        xfer("wr_miss", 1'b1, 4'hF, Base + 32'h1000, 32'hFF);
        xfer("wr_nosel", 1'b1, 4'hE, Base | 32'h414, 32'hFF);
        xfer("ctrl_nosel", 1'b1, 4'h2, Base, 32'h0);
        xfer("status2", 1'b0, 4'hF, Base | 32'h004, 32'h0);

        // Abandoned IMEM read: cycle drops while in MEM.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = Base | 32'h420;
        @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        r = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) r++;
        end
        check("abandon.noack", r, 0);
        xfer("after_abandon", 1'b0, 4'hF, Base | 32'h420, 32'h0);

        // Counter saturation: preload near the top, then write past it.
        xfer("ctrl_clr", 1'b1, 4'h1, Base, 32'h1);
        force dut.wrcnt_q = 16'hFFFD;
        @(posedge wb_clk_i);
        #1;
        release dut.wrcnt_q;
        m_wrcnt = 65533;
        for (int i = 0; i < 3; i++) xfer("sat_wr", 1'b1, 4'h1, Base | 32'h500, 32'(i));
        xfer("sat_status", 1'b0, 4'hF, Base | 32'h004, 32'h0);
        xfer("sat_clr", 1'b1, 4'h1, Base, 32'h1);
        xfer("sat_status0", 1'b0, 4'hF, Base | 32'h004, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r        = $urandom_range(0, 99);
            cpu_pc_i = 8'($urandom);
            if (r < 35) begin
                xfer("r_imwr", 1'b1, ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF,
                     Base | 32'h400 | (32'($urandom_range(0, 255)) << 2), $urandom);
            end else if (r < 65) begin
                xfer("r_imrd", 1'b0, 4'hF, Base | 32'h400 | (32'($urandom_range(0, 255)) << 2),
                     32'h0);
            end else if (r < 72) begin
                xfer("r_ctrlwr", 1'b1, 4'($urandom), Base, $urandom);
            end else if (r < 80) begin
                xfer("r_status", 1'b0, 4'hF, Base | 32'h004, 32'h0);
            end else if (r < 84) begin
                xfer("r_ctrlrd", 1'b0, 4'hF, Base, 32'h0);
            end else if (r < 92) begin
                adr = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(2, 255)) << 2)
                                                  : (32'h800 | (32'($urandom_range(0, 511)) << 2));
                xfer("r_unmap", 1'($urandom), 4'hF, Base | adr, $urandom);
            end else begin
                adr = $urandom;
                if ((adr & Mask) == Base) adr = adr ^ 32'h0000_1000;
                xfer("r_miss", 1'($urandom), 4'hF, adr, $urandom);
            end
        end
        xfer("r_status_end", 1'b0, 4'hF, Base | 32'h004, 32'h0);

        // Reset during the MEM cycle of a write with the CPU running.
        xfer("pre_rst_run", 1'b1, 4'h1, Base, 32'h1);
        we0       = we_total;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'h1;
        wbs_adr_i = Base | 32'h430;
        wbs_dat_i = 32'hA5;
        @(posedge wb_clk_i);
        #1;
        check("mrst.we_before", {31'h0, mem_we_o}, 32'h1);
        wb_rst_i = 1'b1;
        #1;
        check("mrst.we", {31'h0, mem_we_o}, 32'h0);
        check("mrst.ack", {31'h0, wbs_ack_o}, 32'h0);
        check("mrst.cpurst", {31'h0, cpu_rst_o}, 32'h1);
        check("mrst.stall", {31'h0, cpu_stall_o}, 32'h0);
        r = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) r++;
        end
        check("mrst.noack", r, 0);
        check("mrst.nowrite", we_total - we0, 0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wb_rst_i  = 1'b0;
        model_reset();
        @(posedge wb_clk_i);
        #1;
        xfer("post_rst_status", 1'b0, 4'hF, Base | 32'h004, 32'h0);
        xfer("post_rst_mem", 1'b0, 4'hF, Base | 32'h430, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_imem_arbiter.md
WB_IMEM_ARBITER -- requirements
Module: wb_imem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base of the block.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFFF_F000, bits compared against BASE_ADDR for decode.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-006 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte selects, address, write data.
REQ-007 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge and read data.
REQ-008 SHALL have port cpu_pc_i  in  8  CPU instruction-fetch address.
REQ-009 SHALL have port cpu_rst_o  out  1  CPU reset, high while the CPU is not running.
REQ-010 SHALL have port cpu_stall_o  out  1  CPU stall, high while the host owns the memory port.
REQ-011 SHALL have ports mem_addr_o  out  8, mem_we_o  out  1, mem_wdata_o  out  8  instruction-memory port; synchronous read.
REQ-012 SHALL have port mem_rdata_i  in  8  memory read data, valid the cycle after mem_addr_o is presented.

Function
REQ-013 SHALL decode a hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR; offset = wbs_adr_i[11:0].
REQ-014 SHALL map: 0x000 CTRL (bit0 RUN, R/W); 0x004 STATUS (RO: [15:0] WRCNT, [16] RUN); 0x400-0x7FC IMEM, entry = offset[9:2], data in bits [7:0].
REQ-015 SHALL implement FSM states IDLE, MEM, RDWAIT, ACK.
REQ-016 SHALL accept a request only in IDLE with wbs_cyc_i & wbs_stb_i & hit.
REQ-017 SHALL, for IMEM accesses: IDLE->MEM; write: MEM->ACK; read: MEM->RDWAIT->ACK; ACK->IDLE.
REQ-018 SHALL, for CTRL/STATUS and unmapped offsets: IDLE->ACK directly.
REQ-019 SHALL assert wbs_ack_o for exactly one cycle, only in ACK; no request is accepted during ACK.
REQ-020 SHALL give latency from request sampled to ack high: registers 1 cycle, IMEM write 2 cycles, IMEM read 3 cycles.
REQ-021 SHALL, in MEM, drive mem_addr_o = offset[9:2], mem_we_o = wbs_we_i & wbs_sel_i[0], mem_wdata_o = wbs_dat_i[7:0].
REQ-022 SHALL, in all other states, drive mem_addr_o = cpu_pc_i, mem_we_o = 0.
REQ-023 SHALL capture mem_rdata_i in RDWAIT and return it zero-extended on wbs_dat_o in ACK.
REQ-024 SHALL hold wbs_dat_o at 0 except in ACK of a read; unmapped reads return 0 and writes have no effect.
REQ-025 SHALL drive cpu_stall_o = RUN & (state == MEM or RDWAIT); cpu_rst_o = ~RUN.
REQ-026 SHALL, on a CTRL write with sel[0]=1, update RUN from dat[0] and clear WRCNT to 0.
REQ-027 SHALL increment WRCNT on each IMEM write with sel[0]=1, saturating at 16'hFFFF.
REQ-028 SHALL ignore writes with sel[0]=0 (no state change) but still acknowledge them.
REQ-029 SHALL abandon the transaction without ack if wbs_cyc_i drops before ACK, returning to IDLE.

Reset
REQ-030 SHALL, on wb_rst_i high, immediately force state=IDLE, RUN=0, WRCNT=0, wbs_ack_o=0, wbs_dat_o=0, mem_we_o=0, cpu_stall_o=0, cpu_rst_o=1.
REQ-031 SHALL abort any in-flight transaction on reset; no ack is issued, and no memory write occurs after reset asserts.

Verification
REQ-032 SHALL verify: reset, write 0x5A to 0x3000_0410 -> mem_we_o pulse, addr 0x04, wdata 0x5A, ack 2 cycles after strobe, STATUS reads 0x0000_0001.
REQ-033 SHALL verify: memory model returns 0xC3 at entry 0x04, read 0x3000_0410 -> ack after 3 cycles, wbs_dat_o = 0x0000_00C3.
REQ-034 SHALL verify: write CTRL=1 -> cpu_rst_o falls next cycle; a later IMEM read raises cpu_stall_o for exactly 2 cycles.
REQ-035 SHALL verify: 65537 IMEM writes -> WRCNT reads 0xFFFF; CTRL write then clears it to 0.
REQ-036 SHALL verify: read 0x3000_0100 or 0x3000_1000 -> ack with 0 (unmapped) or no ack (miss), with no memory write in either case.
REQ-037 SHALL verify: wb_rst_i asserted in MEM of a write -> no ack, mem_we_o low, and cpu_rst_o=1.
